// File: rtl/simd_pipe_pkg.sv
// Shared field map, instruction decode helpers and forwarding-entry type for the SIMD pipeline controller.
package simd_pipe_pkg;

    localparam int SIMD_DATA_W  = 128;
    localparam int SIMD_INSTR_W = 25;
    localparam int SIMD_RADDR_W = 5;

    localparam int RD_LSB  = 0;
    localparam int RS1_LSB = 5;
    localparam int RS2_LSB = 10;
    localparam int RS3_LSB = 15;

    typedef enum logic [1:0] {
        RS1 = 2'd0,
        RS2 = 2'd1,
        RS3 = 2'd2,
        RD  = 2'd3
    } src_e;

    typedef struct packed {
        logic                    valid;
        logic [SIMD_RADDR_W-1:0] rd;
        logic [SIMD_DATA_W-1:0]  data;
    } fwd_entry_t;

    // A nop is an R3 encoding whose low four rs3 bits are zero; everything else writes rd.
    function automatic logic writes_rd(input logic [SIMD_INSTR_W-1:0] instr);
        return !((instr[24:23] == 2'b11) && (instr[18:15] == 4'b0000));
    endfunction

    function automatic logic [SIMD_RADDR_W-1:0] src_idx(input logic [SIMD_INSTR_W-1:0] instr,
                                                        input src_e k);
        case (k)
            RS1:     return instr[RS1_LSB +: SIMD_RADDR_W];
            RS2:     return instr[RS2_LSB +: SIMD_RADDR_W];
            RS3:     return instr[RS3_LSB +: SIMD_RADDR_W];
            default: return instr[RD_LSB +: SIMD_RADDR_W];
        endcase
    endfunction

endpackage

// File: rtl/simd_pipe_ctrl_fwd.sv
// simd_fwd_unit: priority forwarding mux for one EX source operand.
// The WB beat beats every history entry; among history entries the lowest index (newest) wins.
module simd_fwd_unit
    import simd_pipe_pkg::*;
#(
    parameter int DATA_W    = SIMD_DATA_W,
    parameter int RADDR_W   = SIMD_RADDR_W,
    parameter int FWD_DEPTH = 2
) (
    input  logic [RADDR_W-1:0]                  src_idx_i,
    input  logic                                wb_hit_i,
    input  logic [RADDR_W-1:0]                  wb_rd_i,
    input  logic [DATA_W-1:0]                   wb_data_i,
    input  logic [FWD_DEPTH-1:0]                hist_valid_i,
    input  logic [FWD_DEPTH-1:0][RADDR_W-1:0]   hist_rd_i,
    input  logic [FWD_DEPTH-1:0][DATA_W-1:0]    hist_data_i,
    input  logic [DATA_W-1:0]                   reg_val_i,
    output logic [DATA_W-1:0]                   op_o,
    output logic                                fwd_o
);

    always_comb begin
        op_o  = reg_val_i;
        fwd_o = 1'b0;
        // Walk oldest to newest so later (newer) matches overwrite older ones.
        for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
            if (hist_valid_i[i] && (hist_rd_i[i] == src_idx_i)) begin
                op_o  = hist_data_i[i];
                fwd_o = 1'b1;
            end
        end
        if (wb_hit_i && (wb_rd_i == src_idx_i)) begin
            op_o  = wb_data_i;
            fwd_o = 1'b1;
        end
    end

endmodule

// File: rtl/simd_pipe_ctrl.sv
// ID/EX and EX/WB pipeline registers with stall/flush and result forwarding for the SIMD unit.
// Optional macro SIMD_PIPE_PERF_EN adds perf_retired/perf_fwd counters and ports.
module simd_pipe_ctrl
    import simd_pipe_pkg::*;
#(
    parameter int DATA_W    = SIMD_DATA_W,
    parameter int INSTR_W   = SIMD_INSTR_W,
    parameter int RADDR_W   = SIMD_RADDR_W,
    parameter int FWD_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        id_valid,
    output logic                        id_ready,
    input  logic [INSTR_W-1:0]          id_instr,
    input  logic [3:0][DATA_W-1:0]      id_ops,
    input  logic                        stall,
    input  logic                        flush,
    output logic                        ex_valid,
    output logic [INSTR_W-1:0]          ex_instr,
    output logic [3:0][DATA_W-1:0]      ex_ops,
    output logic [3:0]                  ex_fwd,
    input  logic [DATA_W-1:0]           alu_result,
    output logic                        wb_valid,
    output logic [INSTR_W-1:0]          wb_instr,
    output logic [DATA_W-1:0]           wb_data
`ifdef SIMD_PIPE_PERF_EN
    ,
    output logic [31:0]                 perf_retired,
    output logic [31:0]                 perf_fwd
`endif
);

    logic                   ex_valid_q, ex_valid_d;
    logic [INSTR_W-1:0]     ex_instr_q, ex_instr_d;
    logic [3:0][DATA_W-1:0] ex_ops_q,   ex_ops_d;
    logic                   wb_valid_q, wb_valid_d;
    logic [INSTR_W-1:0]     wb_instr_q, wb_instr_d;
    logic [DATA_W-1:0]      wb_data_q,  wb_data_d;
    fwd_entry_t             hist_q [FWD_DEPTH];
    fwd_entry_t             hist_d [FWD_DEPTH];

    logic                   wb_push;
    logic [RADDR_W-1:0]     wb_rd;

    assign wb_push  = wb_valid_q && writes_rd(wb_instr_q);
    assign wb_rd    = wb_instr_q[RD_LSB +: RADDR_W];
    assign id_ready = !stall && !flush;

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_instr_d = ex_instr_q;
        ex_ops_d   = ex_ops_q;
        wb_valid_d = wb_valid_q;
        wb_instr_d = wb_instr_q;
        wb_data_d  = wb_data_q;
        hist_d     = hist_q;
        // Flush only kills the valids; payloads are don't-care once invalid.
        if (flush) begin
            ex_valid_d = 1'b0;
            wb_valid_d = 1'b0;
        end else if (!stall) begin
            ex_valid_d = id_valid;
            ex_instr_d = id_instr;
            ex_ops_d   = id_ops;
            wb_valid_d = ex_valid_q;
            wb_instr_d = ex_instr_q;
            wb_data_d  = alu_result;
        end
        // The WB beat retires on any unstalled cycle, flush or not.
        if (!stall && wb_push) begin
            for (int i = FWD_DEPTH - 1; i > 0; i--) begin
                hist_d[i] = hist_q[i-1];
            end
            hist_d[0] = '{valid: 1'b1, rd: wb_rd, data: wb_data_q};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid_q <= 1'b0;
            ex_instr_q <= '0;
            ex_ops_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_instr_q <= '0;
            wb_data_q  <= '0;
            for (int i = 0; i < FWD_DEPTH; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_instr_q <= ex_instr_d;
            ex_ops_q   <= ex_ops_d;
            wb_valid_q <= wb_valid_d;
            wb_instr_q <= wb_instr_d;
            wb_data_q  <= wb_data_d;
            hist_q     <= hist_d;
        end
    end

    logic [FWD_DEPTH-1:0]              hist_valid;
    logic [FWD_DEPTH-1:0][RADDR_W-1:0] hist_rd;
    logic [FWD_DEPTH-1:0][DATA_W-1:0]  hist_data;
    logic [DATA_W-1:0]                 fwd_op  [4];
    logic                              fwd_bit [4];

    always_comb begin
        for (int i = 0; i < FWD_DEPTH; i++) begin
            hist_valid[i] = hist_q[i].valid;
            hist_rd[i]    = hist_q[i].rd;
            hist_data[i]  = hist_q[i].data;
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_fwd
        simd_fwd_unit #(
            .DATA_W    (DATA_W),
            .RADDR_W   (RADDR_W),
            .FWD_DEPTH (FWD_DEPTH)
        ) u_fwd (
            .src_idx_i    (src_idx(ex_instr_q, src_e'(k))),
            .wb_hit_i     (wb_push),
            .wb_rd_i      (wb_rd),
            .wb_data_i    (wb_data_q),
            .hist_valid_i (hist_valid),
            .hist_rd_i    (hist_rd),
            .hist_data_i  (hist_data),
            .reg_val_i    (ex_ops_q[k]),
            .op_o         (fwd_op[k]),
            .fwd_o        (fwd_bit[k])
        );
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            ex_ops[k] = fwd_op[k];
            ex_fwd[k] = fwd_bit[k];
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_instr = ex_instr_q;
    assign wb_valid = wb_valid_q;
    assign wb_instr = wb_instr_q;
    assign wb_data  = wb_data_q;

`ifdef SIMD_PIPE_PERF_EN
    logic [31:0] perf_retired_q;
    logic [31:0] perf_fwd_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_retired_q <= '0;
            perf_fwd_q     <= '0;
        end else begin
            if (wb_valid_q && !stall) perf_retired_q <= perf_retired_q + 32'd1;
            if (ex_valid_q && !stall && |ex_fwd) perf_fwd_q <= perf_fwd_q + 32'd1;
        end
    end

    assign perf_retired = perf_retired_q;
    assign perf_fwd     = perf_fwd_q;
`endif

endmodule
